// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the single-cycle MIPS core: owns the PC, fetches over a
// req/ack handshake, holds the instruction until commit and selects the next PC.
module instr_fetch_unit #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    output logic                instr_valid,
    input  logic                commit,
    input  logic                pc_wrt,
    input  logic                jump,
    input  logic                branch,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                halted,
    output logic [PC_WIDTH-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [31:0]           instr_q, instr_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  halted_q, halted_d;
    logic [PC_WIDTH-1:0]   retired_q, retired_d;

    logic [PC_WIDTH-1:0]   pc_plus4_w;
    logic [PC_WIDTH-1:0]   branch_off_w;
    logic [PC_WIDTH-1:0]   branch_tgt_w;
    logic [PC_WIDTH-1:0]   jump_tgt_w;

    // Target arithmetic wraps naturally modulo 2^PC_WIDTH; PC_WIDTH must exceed 28.
    assign pc_plus4_w   = pc_q + PC_WIDTH'(4);
    assign branch_off_w = {{(PC_WIDTH-18){instr_q[15]}}, instr_q[15:0], 2'b00};
    assign branch_tgt_w = pc_plus4_w + branch_off_w;
    assign jump_tgt_w   = {pc_plus4_w[PC_WIDTH-1:28], instr_q[25:0], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            retired_q     <= retired_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        retired_d     = retired_q;
        unique case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (commit) begin
                    instr_valid_d = 1'b0;
                    if (!pc_wrt) begin
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else begin
                        if (jump)
                            pc_d = jump_tgt_w;
                        else if (branch)
                            pc_d = branch_tgt_w;
                        else
                            pc_d = pc_plus4_w;
                        retired_d = retired_q + PC_WIDTH'(1);
                        state_d   = FETCH;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Request is gated by rst_n so it is already low in the cycle reset is asserted.
    assign imem_req    = (state_q == FETCH) && rst_n;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;
    assign halted      = halted_q;
    assign retired_cnt = retired_q;

endmodule
